// File: rtl/fe_pkg.sv
// Shared types for the fe/ pipeline decode path: opcode and mnemonic enums,
// the decoded-instruction record and the decode-stage buffer states.
package fe_pkg;

    localparam int PC_W = 32;

    typedef enum logic [6:0] {
        OPC_NONE   = 7'h00,
        OPC_LOAD   = 7'h03,
        OPC_OP_IMM = 7'h13,
        OPC_AUIPC  = 7'h17,
        OPC_STORE  = 7'h23,
        OPC_OP     = 7'h33,
        OPC_LUI    = 7'h37,
        OPC_BRANCH = 7'h63,
        OPC_JALR   = 7'h67,
        OPC_JAL    = 7'h6F,
        OPC_SYSTEM = 7'h73
    } opcode_e;

    typedef enum logic [5:0] {
        MN_NULL,
        MN_LUI, MN_AUIPC, MN_JAL, MN_JALR,
        MN_BEQ, MN_BNE, MN_BLT, MN_BGE, MN_BLTU, MN_BGEU,
        MN_LB, MN_LH, MN_LW, MN_LBU, MN_LHU,
        MN_SB, MN_SH, MN_SW,
        MN_ADDI, MN_SLTI, MN_SLTIU, MN_XORI, MN_ORI, MN_ANDI, MN_SLLI, MN_SRLI, MN_SRAI,
        MN_ADD, MN_SUB, MN_SLL, MN_SLT, MN_SLTU, MN_XOR, MN_SRL, MN_SRA, MN_OR, MN_AND,
        MN_ECALL, MN_EBREAK,
        MN_MUL, MN_MULH, MN_MULHSU, MN_MULHU, MN_DIV, MN_DIVU, MN_REM, MN_REMU
    } mnemonic_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [31:0]     imm;
        opcode_e         opcode;
        mnemonic_e       mnemonic;
        logic            rd_we;
        logic            illegal;
    } decoded_t;

endpackage

// File: rtl/rv32_decode_core.sv
// Combinational RV32I(+M) decoder: instruction word and PC in, decoded record out.
// Any encoding that maps to no mnemonic is flagged illegal and never writes rd.
module rv32_decode_core
    import fe_pkg::*;
#(
    parameter bit M_EXT = 1'b1
) (
    input  logic [31:0]   instr,
    input  logic [PC_W-1:0] pc,
    output decoded_t      dec
);

    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        writes_rd;
    mnemonic_e   mn;

    assign f7    = instr[31:25];
    assign f3    = instr[14:12];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec       = '0;
        dec.pc    = pc;
        writes_rd = 1'b0;
        mn        = MN_NULL;
        case (instr[6:0])
            7'h37: begin
                dec.opcode = OPC_LUI;   dec.rd = instr[11:7]; dec.imm = imm_u;
                writes_rd = 1'b1;       mn = MN_LUI;
            end
            7'h17: begin
                dec.opcode = OPC_AUIPC; dec.rd = instr[11:7]; dec.imm = imm_u;
                writes_rd = 1'b1;       mn = MN_AUIPC;
            end
            7'h6F: begin
                dec.opcode = OPC_JAL;   dec.rd = instr[11:7]; dec.imm = imm_j;
                writes_rd = 1'b1;       mn = MN_JAL;
            end
            7'h67: begin
                dec.opcode = OPC_JALR;  dec.rs1 = instr[19:15]; dec.rd = instr[11:7];
                dec.imm = imm_i;        writes_rd = 1'b1;
                mn = (f3 == 3'd0) ? MN_JALR : MN_NULL;
            end
            7'h63: begin
                dec.opcode = OPC_BRANCH; dec.rs1 = instr[19:15]; dec.rs2 = instr[24:20];
                dec.imm = imm_b;
                case (f3)
                    3'd0: mn = MN_BEQ;   3'd1: mn = MN_BNE;
                    3'd4: mn = MN_BLT;   3'd5: mn = MN_BGE;
                    3'd6: mn = MN_BLTU;  3'd7: mn = MN_BGEU;
                    default: mn = MN_NULL;
                endcase
            end
            7'h03: begin
                dec.opcode = OPC_LOAD;  dec.rs1 = instr[19:15]; dec.rd = instr[11:7];
                dec.imm = imm_i;        writes_rd = 1'b1;
                case (f3)
                    3'd0: mn = MN_LB;    3'd1: mn = MN_LH;   3'd2: mn = MN_LW;
                    3'd4: mn = MN_LBU;   3'd5: mn = MN_LHU;
                    default: mn = MN_NULL;
                endcase
            end
            7'h23: begin
                dec.opcode = OPC_STORE; dec.rs1 = instr[19:15]; dec.rs2 = instr[24:20];
                dec.imm = imm_s;
                case (f3)
                    3'd0: mn = MN_SB;    3'd1: mn = MN_SH;   3'd2: mn = MN_SW;
                    default: mn = MN_NULL;
                endcase
            end
            7'h13: begin
                dec.opcode = OPC_OP_IMM; dec.rs1 = instr[19:15]; dec.rd = instr[11:7];
                dec.imm = imm_i;         writes_rd = 1'b1;
                // Shift-immediates reuse the top bits of imm as funct7.
                case (f3)
                    3'd0: mn = MN_ADDI;  3'd2: mn = MN_SLTI;  3'd3: mn = MN_SLTIU;
                    3'd4: mn = MN_XORI;  3'd6: mn = MN_ORI;   3'd7: mn = MN_ANDI;
                    3'd1: mn = (f7 == 7'h00) ? MN_SLLI : MN_NULL;
                    default: mn = (f7 == 7'h00) ? MN_SRLI :
                                  (f7 == 7'h20) ? MN_SRAI : MN_NULL;
                endcase
            end
            7'h33: begin
                dec.opcode = OPC_OP;    dec.rs1 = instr[19:15]; dec.rs2 = instr[24:20];
                dec.rd = instr[11:7];   writes_rd = 1'b1;
                case (f7)
                    7'h00: case (f3)
                        3'd0: mn = MN_ADD;  3'd1: mn = MN_SLL;  3'd2: mn = MN_SLT;
                        3'd3: mn = MN_SLTU; 3'd4: mn = MN_XOR;  3'd5: mn = MN_SRL;
                        3'd6: mn = MN_OR;   default: mn = MN_AND;
                    endcase
                    7'h20: mn = (f3 == 3'd0) ? MN_SUB : (f3 == 3'd5) ? MN_SRA : MN_NULL;
                    7'h01: if (M_EXT) begin
                        case (f3)
                            3'd0: mn = MN_MUL;  3'd1: mn = MN_MULH;  3'd2: mn = MN_MULHSU;
                            3'd3: mn = MN_MULHU; 3'd4: mn = MN_DIV;  3'd5: mn = MN_DIVU;
                            3'd6: mn = MN_REM;  default: mn = MN_REMU;
                        endcase
                    end
                    default: mn = MN_NULL;
                endcase
            end
            7'h73: begin
                dec.opcode = OPC_SYSTEM; dec.rs1 = instr[19:15]; dec.rd = instr[11:7];
                dec.imm = imm_i;
                mn = (instr == 32'h0000_0073) ? MN_ECALL :
                     (instr == 32'h0010_0073) ? MN_EBREAK : MN_NULL;
            end
            default: mn = MN_NULL;
        endcase
        dec.mnemonic = mn;
        dec.illegal  = (mn == MN_NULL);
        dec.rd_we    = writes_rd && (mn != MN_NULL) && (dec.rd != 5'd0);
    end

endmodule

// File: rtl/rv32_decode_stage.sv
// Registered decode stage between fetch and execute: a main output register plus
// a skid entry so in_ready comes straight from a flop and throughput stays 1/cycle.
module rv32_decode_stage
    import fe_pkg::*;
#(
    parameter bit M_EXT    = 1'b1,
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [4:0]          out_rd,
    output logic [31:0]         out_imm,
    output opcode_e             out_opcode,
    output mnemonic_e           out_mnemonic,
    output logic                out_rd_we,
    output logic                out_illegal,
    output stage_state_e        dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready and payload holds while valid && !ready.
    decoded_t     dec;
    decoded_t     main_q, main_d, skid_q, skid_d;
    stage_state_e state_q, state_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         accept, fire;

    rv32_decode_core #(.M_EXT(M_EXT)) u_core (
        .instr (in_instr),
        .pc    (PC_W'(in_pc)),
        .dec   (dec)
    );

    assign accept = in_valid && in_ready_q;
    assign fire   = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) begin
                    main_d  = dec;
                    state_d = ST_ONE;
                end
                ST_ONE: begin
                    if (accept && fire) begin
                        main_d = dec;
                    end else if (accept) begin
                        skid_d  = dec;
                        state_d = ST_TWO;
                    end else if (fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: if (fire) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_pc       = PC_WIDTH'(main_q.pc);
    assign out_rs1      = main_q.rs1;
    assign out_rs2      = main_q.rs2;
    assign out_rd       = main_q.rd;
    assign out_imm      = main_q.imm;
    assign out_opcode   = main_q.opcode;
    assign out_mnemonic = main_q.mnemonic;
    assign out_rd_we    = main_q.rd_we;
    assign out_illegal  = main_q.illegal;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Bench for rv32_decode_stage: directed literal cases, ordering/flush/reset
// scenarios and a randomized run against a transaction-level model.
module tb_rv32_decode_stage;
    import fe_pkg::*;

    logic        clk, rst, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;

    logic         in_ready, out_valid, out_rd_we, out_illegal;
    logic [31:0]  out_pc, out_imm;
    logic [4:0]   out_rs1, out_rs2, out_rd;
    opcode_e      out_opcode;
    mnemonic_e    out_mnemonic;
    stage_state_e dbg_state;

    logic         in_ready_b, out_valid_b, out_rd_we_b, out_illegal_b;
    logic [31:0]  out_pc_b, out_imm_b;
    logic [4:0]   out_rs1_b, out_rs2_b, out_rd_b;
    opcode_e      out_opcode_b;
    mnemonic_e    out_mnemonic_b;
    stage_state_e dbg_state_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit seen_100 = 0;

    logic [63:0] exp_q[$];   // {pc, instr} of every accepted instruction not yet fired

    mnemonic_e br_tab  [8] = '{MN_BEQ, MN_BNE, MN_NULL, MN_NULL, MN_BLT, MN_BGE, MN_BLTU, MN_BGEU};
    mnemonic_e ld_tab  [8] = '{MN_LB, MN_LH, MN_LW, MN_NULL, MN_LBU, MN_LHU, MN_NULL, MN_NULL};
    mnemonic_e st_tab  [8] = '{MN_SB, MN_SH, MN_SW, MN_NULL, MN_NULL, MN_NULL, MN_NULL, MN_NULL};
    mnemonic_e alu_tab [8] = '{MN_ADD, MN_SLL, MN_SLT, MN_SLTU, MN_XOR, MN_SRL, MN_OR, MN_AND};
    mnemonic_e imm_tab [8] = '{MN_ADDI, MN_SLLI, MN_SLTI, MN_SLTIU, MN_XORI, MN_SRLI, MN_ORI, MN_ANDI};
    mnemonic_e mul_tab [8] = '{MN_MUL, MN_MULH, MN_MULHSU, MN_MULHU, MN_DIV, MN_DIVU, MN_REM, MN_REMU};
    logic [6:0] op_tab [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    logic [6:0] f7_tab [3]  = '{7'h00, 7'h20, 7'h01};

    rv32_decode_stage #(.M_EXT(1'b1), .PC_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_opcode(out_opcode), .out_mnemonic(out_mnemonic),
        .out_rd_we(out_rd_we), .out_illegal(out_illegal), .dbg_state(dbg_state)
    );

    rv32_decode_stage #(.M_EXT(1'b0), .PC_WIDTH(32)) dut_nom (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_pc(out_pc_b), .out_rs1(out_rs1_b), .out_rs2(out_rs2_b), .out_rd(out_rd_b),
        .out_imm(out_imm_b), .out_opcode(out_opcode_b), .out_mnemonic(out_mnemonic_b),
        .out_rd_we(out_rd_we_b), .out_illegal(out_illegal_b), .dbg_state(dbg_state_b)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic decoded_t ref_decode(input logic [31:0] w, input logic [31:0] pc, input bit m);
        decoded_t  e;
        mnemonic_e mn;
        byte       fmt;
        logic [6:0] op, f7;
        logic [2:0] f3;
        op  = w[6:0];
        f7  = w[31:25];
        f3  = w[14:12];
        e   = '0;
        e.pc = pc;
        mn  = MN_NULL;
        fmt = "N";
        case (op)
            7'h37: begin fmt = "U"; mn = MN_LUI; end
            7'h17: begin fmt = "U"; mn = MN_AUIPC; end
            7'h6F: begin fmt = "J"; mn = MN_JAL; end
            7'h67: begin fmt = "I"; if (f3 == 0) mn = MN_JALR; end
            7'h63: begin fmt = "B"; mn = br_tab[f3]; end
            7'h03: begin fmt = "I"; mn = ld_tab[f3]; end
            7'h23: begin fmt = "S"; mn = st_tab[f3]; end
            7'h13: begin
                fmt = "I";
                if (f3 == 1)      mn = (f7 == 0) ? MN_SLLI : MN_NULL;
                else if (f3 == 5) mn = (f7 == 0) ? MN_SRLI : (f7 == 7'h20) ? MN_SRAI : MN_NULL;
                else              mn = imm_tab[f3];
            end
            7'h33: begin
                fmt = "R";
                if (f7 == 0)                    mn = alu_tab[f3];
                else if (f7 == 7'h20 && f3 == 0) mn = MN_SUB;
                else if (f7 == 7'h20 && f3 == 5) mn = MN_SRA;
                else if (f7 == 7'h01 && m)       mn = mul_tab[f3];
            end
            7'h73: begin
                fmt = "I";
                if (w == 32'h0000_0073)      mn = MN_ECALL;
                else if (w == 32'h0010_0073) mn = MN_EBREAK;
            end
            default: fmt = "N";
        endcase
        if (fmt inside {"R", "I", "S", "B"}) e.rs1 = w[19:15];
        if (fmt inside {"R", "S", "B"})      e.rs2 = w[24:20];
        if (fmt inside {"R", "I", "U", "J"}) e.rd  = w[11:7];
        case (fmt)
            "I": e.imm = {{20{w[31]}}, w[31:20]};
            "S": e.imm = {{20{w[31]}}, w[31:25], w[11:7]};
            "B": e.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            "U": e.imm = {w[31:12], 12'b0};
            "J": e.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: e.imm = 32'd0;
        endcase
        e.opcode   = (fmt == "N") ? OPC_NONE : opcode_e'(op);
        e.mnemonic = mn;
        e.illegal  = (mn == MN_NULL);
        e.rd_we    = (fmt inside {"R", "U", "J"} || (fmt == "I" && op != 7'h73))
                     && !e.illegal && (e.rd != 0);
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) != 0) w[6:0] = op_tab[$urandom_range(0, 9)];
        if ((w[6:0] == 7'h13 || w[6:0] == 7'h33) && $urandom_range(0, 1) == 1)
            w[31:25] = f7_tab[$urandom_range(0, 2)];
        if (w[6:0] == 7'h73 && $urandom_range(0, 2) != 0)
            w = ($urandom_range(0, 1) == 1) ? 32'h0010_0073 : 32'h0000_0073;
        return w;
    endfunction

    // Occupancy model: pop on fire, push on accept, cleared by flush or reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
        end else if (flush) begin
            exp_q.delete();
        end else begin
            bit acc, fir;
            acc = in_valid && (exp_q.size() < 2);
            fir = (exp_q.size() > 0) && out_ready;
            if (fir) void'(exp_q.pop_front());
            if (acc) exp_q.push_back({in_pc, in_instr});
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dec(input string tag, input decoded_t a, input decoded_t e);
        check({tag, ".pc"},       a.pc,       e.pc);
        check({tag, ".rs1"},      a.rs1,      e.rs1);
        check({tag, ".rs2"},      a.rs2,      e.rs2);
        check({tag, ".rd"},       a.rd,       e.rd);
        check({tag, ".imm"},      a.imm,      e.imm);
        check({tag, ".opcode"},   a.opcode,   e.opcode);
        check({tag, ".mnemonic"}, a.mnemonic, e.mnemonic);
        check({tag, ".rd_we"},    a.rd_we,    e.rd_we);
        check({tag, ".illegal"},  a.illegal,  e.illegal);
    endtask

    decoded_t act_m, act_n;
    always_comb begin
        act_m = '{pc: out_pc, rs1: out_rs1, rs2: out_rs2, rd: out_rd, imm: out_imm,
                  opcode: out_opcode, mnemonic: out_mnemonic, rd_we: out_rd_we, illegal: out_illegal};
        act_n = '{pc: out_pc_b, rs1: out_rs1_b, rs2: out_rs2_b, rd: out_rd_b, imm: out_imm_b,
                  opcode: out_opcode_b, mnemonic: out_mnemonic_b, rd_we: out_rd_we_b,
                  illegal: out_illegal_b};
    end

    always @(negedge clk) begin
        if (!rst) begin
            stage_state_e exp_st;
            exp_st = (exp_q.size() == 0) ? ST_EMPTY : (exp_q.size() == 1) ? ST_ONE : ST_TWO;
            check("out_valid",   out_valid,   exp_q.size() != 0);
            check("in_ready",    in_ready,    exp_q.size() < 2);
            check("state",       dbg_state,   exp_st);
            check("nom.out_valid", out_valid_b, exp_q.size() != 0);
            check("nom.in_ready",  in_ready_b,  exp_q.size() < 2);
            if (exp_q.size() != 0) begin
                check_dec("m", act_m, ref_decode(exp_q[0][31:0], exp_q[0][63:32], 1'b1));
                check_dec("nom", act_n, ref_decode(exp_q[0][31:0], exp_q[0][63:32], 1'b0));
            end
            if (out_valid && out_pc == 32'h100) seen_100 = 1'b1;
        end
    end

    // ---------------- driver ----------------
    // Called at posedge+2; returns at accept edge + 2.
    task automatic push(input logic [31:0] w, input logic [31:0] pc);
        bit r, ok;
        ok = 0;
        in_valid = 1'b1;
        in_instr = w;
        in_pc    = pc;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            if (r) begin
                ok = 1;
                break;
            end
        end
        #2;
        in_valid = 1'b0;
        check("push_accepted", ok, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst.out_valid", out_valid, 0);
        check("rst.in_ready",  in_ready,  1);
        check("rst.mnemonic",  out_mnemonic, MN_NULL);
        check("rst.illegal",   out_illegal, 0);
        check("rst.imm",       out_imm, 0);
        check("rst.pc",        out_pc, 0);
        idle(1);

        // Directed literal decodes.
        push(32'h002081B3, 32'h0);
        @(negedge clk);
        check("add.mnemonic", out_mnemonic, MN_ADD);
        check("add.rs1", out_rs1, 1);
        check("add.rs2", out_rs2, 2);
        check("add.rd",  out_rd, 3);
        check("add.rd_we", out_rd_we, 1);
        check("add.illegal", out_illegal, 0);
        idle(1);
        push(32'h022081B3, 32'h4);
        @(negedge clk);
        check("mul.mnemonic", out_mnemonic, MN_MUL);
        check("mul_nom.illegal", out_illegal_b, 1);
        check("mul_nom.mnemonic", out_mnemonic_b, MN_NULL);
        check("mul_nom.rd_we", out_rd_we_b, 0);
        idle(1);
        push(32'hFE000EE3, 32'h8);
        @(negedge clk);
        check("beq.mnemonic", out_mnemonic, MN_BEQ);
        check("beq.imm", out_imm, 32'hFFFF_FFFC);
        check("beq.rd_we", out_rd_we, 0);
        idle(1);
        push(32'h123452B7, 32'hC);
        @(negedge clk);
        check("lui.mnemonic", out_mnemonic, MN_LUI);
        check("lui.rd", out_rd, 5);
        check("lui.imm", out_imm, 32'h1234_5000);
        idle(1);
        push(32'h00100073, 32'h10);
        @(negedge clk);
        check("ebreak.mnemonic", out_mnemonic, MN_EBREAK);
        idle(1);
        push(32'h00200073, 32'h14);
        @(negedge clk);
        check("env_bad.illegal", out_illegal, 1);
        check("env_bad.mnemonic", out_mnemonic, MN_NULL);
        idle(2);

        // Back-to-back stream under 2 cycles of backpressure.
        out_ready = 1'b0;
        push(32'h002081B3, 32'h0);
        push(32'h40208133, 32'h4);
        fork
            push(32'h00500093, 32'h8);
            begin
                @(negedge clk);
                check("stream.in_ready_low", in_ready, 0);
                @(posedge clk);
                #2 out_ready = 1'b1;
                @(negedge clk);
                check("stream.v0", out_valid, 1);
                check("stream.pc0", out_pc, 32'h0);
                @(negedge clk);
                check("stream.v1", out_valid, 1);
                check("stream.pc1", out_pc, 32'h4);
                @(negedge clk);
                check("stream.v2", out_valid, 1);
                check("stream.pc2", out_pc, 32'h8);
            end
        join
        idle(3);

        // Flush while full, with a competing input offered the same cycle.
        out_ready = 1'b0;
        push(32'h002081B3, 32'h10);
        push(32'h002081B3, 32'h14);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h100;
        @(posedge clk);
        #2 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush.out_valid", out_valid, 0);
        check("flush.in_ready", in_ready, 1);
        check("flush.state", dbg_state, ST_EMPTY);
        out_ready = 1'b1;
        idle(4);
        check("flush.dropped_pc_seen", seen_100, 0);

        // Asynchronous reset while full.
        out_ready = 1'b0;
        push(32'h002081B3, 32'h20);
        push(32'h123452B7, 32'h24);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst.out_valid", out_valid, 0);
        check("arst.pc", out_pc, 0);
        check("arst.mnemonic", out_mnemonic, MN_NULL);
        check("arst.illegal", out_illegal, 0);
        check("arst.rd", out_rd, 0);
        check("arst.state", dbg_state, ST_EMPTY);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        idle(1);
        push(32'h002081B3, 32'h30);
        @(negedge clk);
        check("arst.resume_pc", out_pc, 32'h30);
        check("arst.resume_mn", out_mnemonic, MN_ADD);
        idle(2);

        // Randomized traffic.
        begin
            logic [31:0] pc_ctr;
            pc_ctr = 32'h1000;
            for (int c = 0; c < 400; c++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_instr  = gen_instr();
                in_pc     = pc_ctr;
                pc_ctr    = pc_ctr + 4;
                out_ready = ($urandom_range(0, 3) != 0);
                flush     = ($urandom_range(0, 39) == 0);
                @(posedge clk);
                #2;
            end
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32_decode_stage.md
# rv32_decode_stage

Registered, flow-controlled RV32 decode stage; successor to the combinational RV32I decoder. Accepts one fetched instruction word plus PC per cycle over a valid/ready handshake, decodes fields, immediate, mnemonic and an illegal-instruction flag, and presents them registered to execute. A two-entry skid buffer gives full throughput under backpressure. Optional M-extension decode and a pipeline flush are included. Sits between fetch and execute in the fe/ pipeline.

## Interface
- M_EXT, 1, 1 = decode MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; 0 = those encodings flag illegal
- PC_WIDTH, 32, width of the PC passed through with each instruction
- clk  input  1  clock; everything is on the rising edge
- rst  input  1  reset, asynchronous, active-high
- flush  input  1  drops all buffered instructions
- in_valid / in_ready  input / output  1 / 1  upstream handshake
- in_instr  input  32  raw instruction word
- in_pc  input  PC_WIDTH  PC of in_instr
- out_valid / out_ready  output / input  1 / 1  downstream handshake
- out_pc  output  PC_WIDTH  PC passthrough
- out_rs1, out_rs2, out_rd  output  5 each  register addresses; 0 when the format has no such field
- out_imm  output  32  sign-extended immediate for the format
- out_opcode  output  7  opcode type enum
- out_mnemonic  output  mnemonic enum  mnemonic, including M mnemonics; NULL when illegal
- out_rd_we  output  1  1 only for formats that write rd, and only when rd != 0
- out_illegal  output  1  encoding is not a legal RV32I(+M) instruction

## Operation
- Field and immediate extraction per format:
  - R: no immediate.
  - I / LOAD / JALR / ENV: imm = sext(instr[31:20]).
  - S: imm = sext({instr[31:25], instr[11:7]}).
  - B: imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U: imm = {instr[31:12], 12'b0}.
  - J: imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- out_illegal = 1, out_mnemonic = NULL, out_rd_we = 0 for any of:
  - instr[1:0] != 2'b11, or unknown opcode.
  - R-type: funct7 not in {0x00, 0x20, 0x01 when M_EXT}; funct7 = 0x20 with funct3 other than 0 or 5.
  - SLLI with funct7 != 0; SRLI/SRAI with funct7 not in {0x00, 0x20}.
  - Load with funct3 in {3, 6, 7}; store with funct3 > 2; branch with funct3 in {2, 3}; JALR with funct3 != 0.
  - ENV with instr not equal to 0x00000073 (ECALL) or 0x00100073 (EBREAK).
- Buffering: a main output register plus one skid register. FSM states:
  - EMPTY → ONE on input accept.
  - ONE → TWO on accept without output fire.
  - ONE → EMPTY on output fire without accept.
  - TWO → ONE on output fire; the skid entry moves into the main register.
- in_ready = !skid_valid, driven straight from a flop with no combinational path from out_ready.
- out_valid = 1 in ONE and TWO.
- Order is strictly preserved; no instruction is lost or duplicated.

## Timing
- Latency: an instruction accepted at edge N is on the outputs after edge N; out_valid is visible in cycle N+1.
- Throughput: 1 instruction/cycle while out_ready = 1.
- Reset values: out_valid = 0, every payload output = 0, out_mnemonic = NULL, out_illegal = 0, state EMPTY. in_ready = 1 from the first cycle after reset deasserts.
- Outputs hold stable while out_valid && !out_ready.
- Simultaneous accept and fire in ONE: state stays ONE and the main register loads the new decode.
- flush has priority over everything. At the next edge the state is EMPTY and any in_valid offered in that cycle is dropped. out_valid = 0 and in_ready = 1 in the following cycle.
- Reset asserted mid-transfer clears state asynchronously; buffered entries are discarded.

## Structure
- fe_pkg holds the opcode enum and the mnemonic enum, extended with the 8 M-extension mnemonics, plus a decoded-instruction packed struct (pc, rs1, rs2, rd, imm, opcode, mnemonic, rd_we, illegal).
- The PC_WIDTH field of that struct uses the package default of 32.
- Sub-module rv32_decode_core: purely combinational, maps instruction to the struct, parametrised by M_EXT.
- rv32_decode_stage contains only the skid FSM and two struct registers.

## Test plan
- 0x002081B3 (add x3,x1,x2) → next cycle: ADD, rs1 = 1, rs2 = 2, rd = 3, rd_we = 1, illegal = 0.
- 0x022081B3 → MUL with M_EXT = 1; with M_EXT = 0: illegal = 1, mnemonic = NULL, rd_we = 0.
- 0xFE000EE3 → BEQ, imm = 0xFFFFFFFC, rd_we = 0. 0x123452B7 → LUI, rd = 5, imm = 0x12345000. 0x00100073 → EBREAK. 0x00200073 → illegal.
- Stream PCs 0x0, 0x4, 0x8 back-to-back with out_ready low for 2 cycles:
  - in_ready falls after the 2nd accept.
  - The third instruction waits until in_ready returns.
  - Outputs appear in order 0x0, 0x4, 0x8 with no gaps once out_ready = 1.
- State TWO plus flush, with in_valid high in the same cycle → next cycle out_valid = 0, in_ready = 1; the dropped PC never appears.
- Assert rst asynchronously mid-clock while in state TWO → outputs go to reset values immediately; after release, decoding resumes with the first new instruction.
